// File: rtl/tx_dac_formatter.sv
// tx_dac_formatter: clips the FFE's four signed lanes to the DAC range, converts
// them to offset-binary and buffers them in a shared 4-lane FIFO. The FIFO then
// feeds the DAC through a valid/ready handshake, sequenced by
// IDLE / PRIME / STREAM / DRAIN.
//
// Optional feature: define TX_SAT_COUNT_EN to build the lane-clip event counter.
// Without it, io_sat_count is tied to zero.
//
// Handshake: the input side is valid-only and never stalls. A code set transfers
// to the DAC on every edge where io_dac_valid and io_dac_ready are both high.
// io_dac_valid does not depend on io_dac_ready.
module tx_dac_formatter #(
  parameter int IN_W      = 8,
  parameter int CLIP_LVL  = 100,
  parameter int DEPTH     = 8,
  parameter int PRIME_LVL = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_enable,
  input  logic            io_clear_status,
  input  logic            io_in_valid,
  input  logic [IN_W-1:0] io_in_bits_0,
  input  logic [IN_W-1:0] io_in_bits_1,
  input  logic [IN_W-1:0] io_in_bits_2,
  input  logic [IN_W-1:0] io_in_bits_3,
  input  logic            io_dac_ready,
  output logic            io_dac_valid,
  output logic [IN_W-1:0] io_dac_code_0,
  output logic [IN_W-1:0] io_dac_code_1,
  output logic [IN_W-1:0] io_dac_code_2,
  output logic [IN_W-1:0] io_dac_code_3,
  output logic [1:0]      io_state,
  output logic            io_overflow,
  output logic            io_underflow,
  output logic [15:0]     io_sat_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IN_W-1:0] CLIP_POS  = CLIP_LVL[IN_W-1:0];
  localparam logic signed [IN_W-1:0] CLIP_NEG  = -CLIP_POS;
  localparam logic [IN_W-1:0]        MID_CODE  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [AW:0]            FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]            PRIME_CNT = (AW+1)'(PRIME_LVL);

  state_t                state_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic [4*IN_W-1:0]     mem_q [DEPTH];

  logic [IN_W-1:0]       lane_in   [4];
  logic [IN_W-1:0]       lane_code [4];
  logic [4*IN_W-1:0]     wr_data, rd_data;
  logic                  push_req, push, pop, drop, full, underflow_evt;

  assign lane_in[0] = io_in_bits_0;
  assign lane_in[1] = io_in_bits_1;
  assign lane_in[2] = io_in_bits_2;
  assign lane_in[3] = io_in_bits_3;

  // Per-lane clip, then offset-binary: adding 2^(IN_W-1) mod 2^IN_W flips the MSB
  always_comb begin
    logic [IN_W-1:0] clipped;
    clipped = '0;
    for (int i = 0; i < 4; i++) begin
      clipped = lane_in[i];
      if ($signed(lane_in[i]) > CLIP_POS)      clipped = CLIP_POS;
      else if ($signed(lane_in[i]) < CLIP_NEG) clipped = CLIP_NEG;
      lane_code[i] = {~clipped[IN_W-1], clipped[IN_W-2:0]};
    end
  end

  assign wr_data = {lane_code[3], lane_code[2], lane_code[1], lane_code[0]};
  assign rd_data = mem_q[rd_ptr_q];

  assign full          = (count_q == FULL_CNT);
  assign push_req      = io_in_valid && (state_q == S_PRIME || state_q == S_STREAM);
  assign io_dac_valid  = (state_q == S_STREAM || state_q == S_DRAIN) && (count_q != '0);
  assign pop           = io_dac_valid && io_dac_ready;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge
  assign push          = push_req && (!full || pop);
  assign drop          = push_req && full && !pop;
  assign underflow_evt = (state_q == S_STREAM) && io_enable && (count_q == '0) && io_dac_ready;

  // Occupancy after this edge, before any flush
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Sequencer, FIFO pointers/occupancy and sticky status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;

      if (drop)                 overflow_q <= 1'b1;
      else if (io_clear_status) overflow_q <= 1'b0;
      if (underflow_evt)        underflow_q <= 1'b1;
      else if (io_clear_status) underflow_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (io_enable) state_q <= S_PRIME;
        end
        S_PRIME: begin
          if (!io_enable) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
          end else if (count_d >= PRIME_CNT) begin
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!io_enable)        state_q <= S_DRAIN;
          else if (underflow_evt) state_q <= S_PRIME;
        end
        S_DRAIN: begin
          if (io_enable)            state_q <= S_PRIME;
          else if (count_d == '0)   state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_state      = state_q;
  assign io_overflow   = overflow_q;
  assign io_underflow  = underflow_q;
  assign io_dac_code_0 = io_dac_valid ? rd_data[IN_W-1:0]        : MID_CODE;
  assign io_dac_code_1 = io_dac_valid ? rd_data[2*IN_W-1:IN_W]   : MID_CODE;
  assign io_dac_code_2 = io_dac_valid ? rd_data[3*IN_W-1:2*IN_W] : MID_CODE;
  assign io_dac_code_3 = io_dac_valid ? rd_data[4*IN_W-1:3*IN_W] : MID_CODE;

`ifdef TX_SAT_COUNT_EN
  logic [15:0] sat_q;
  logic [2:0]  sat_inc;
  logic [16:0] sat_sum;

  // Number of lanes clipped in the current input set, and the saturating sum
  always_comb begin
    sat_inc = '0;
    for (int i = 0; i < 4; i++) begin
      if ($signed(lane_in[i]) > CLIP_POS || $signed(lane_in[i]) < CLIP_NEG)
        sat_inc = sat_inc + 3'd1;
    end
    sat_sum = {1'b0, sat_q} + {14'd0, sat_inc};
  end

  // Clip-event counter; clips arriving with a clear still get counted
  always_ff @(posedge clock) begin
    if (reset)                sat_q <= '0;
    else if (io_clear_status) sat_q <= push ? 16'(sat_inc) : 16'd0;
    else if (push)            sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  assign io_sat_count = sat_q;
`else
  assign io_sat_count = '0;
`endif

endmodule

// File: tb/tb_tx_dac_formatter.sv
// Directed bench for tx_dac_formatter with a scoreboard of expected code sets.
module tb_tx_dac_formatter;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_enable, io_clear_status, io_in_valid, io_dac_ready;
  logic [7:0] io_in_bits_0, io_in_bits_1, io_in_bits_2, io_in_bits_3;
  logic       io_dac_valid;
  logic [7:0] io_dac_code_0, io_dac_code_1, io_dac_code_2, io_dac_code_3;
  logic [1:0] io_state;
  logic       io_overflow, io_underflow;
  logic [15:0] io_sat_count;

  int checks   = 0;
  int failures = 0;
  int sat_model = 0;
  logic [31:0] exp_q[$];

  tx_dac_formatter dut (
    .clock(clock), .reset(reset), .io_enable(io_enable),
    .io_clear_status(io_clear_status), .io_in_valid(io_in_valid),
    .io_in_bits_0(io_in_bits_0), .io_in_bits_1(io_in_bits_1),
    .io_in_bits_2(io_in_bits_2), .io_in_bits_3(io_in_bits_3),
    .io_dac_ready(io_dac_ready), .io_dac_valid(io_dac_valid),
    .io_dac_code_0(io_dac_code_0), .io_dac_code_1(io_dac_code_1),
    .io_dac_code_2(io_dac_code_2), .io_dac_code_3(io_dac_code_3),
    .io_state(io_state), .io_overflow(io_overflow),
    .io_underflow(io_underflow), .io_sat_count(io_sat_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [7:0] code_of(input logic [7:0] raw);
    int v;
    v = int'($signed(raw));
    if (v > 100) v = 100;
    else if (v < -100) v = -100;
    return 8'(v + 128);
  endfunction

  function automatic int clips_of(input logic [7:0] raw);
    int v;
    v = int'($signed(raw));
    return (v > 100 || v < -100) ? 1 : 0;
  endfunction

  // driver: one input cycle; accept says whether the model expects it queued
  task automatic push_cycle(input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3, input bit accept);
    io_in_valid  = 1'b1;
    io_in_bits_0 = l0;
    io_in_bits_1 = l1;
    io_in_bits_2 = l2;
    io_in_bits_3 = l3;
    if (accept) begin
      exp_q.push_back({code_of(l3), code_of(l2), code_of(l1), code_of(l0)});
      sat_model += clips_of(l0) + clips_of(l1) + clips_of(l2) + clips_of(l3);
    end
    tick();
    io_in_valid = 1'b0;
  endtask

  task automatic push_rand(input bit accept);
    push_cycle(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), accept);
  endtask

  task automatic clear_pulse();
    io_clear_status = 1'b1;
    sat_model = 0;
    tick();
    io_clear_status = 1'b0;
  endtask

  task automatic check_sat(input string tag);
`ifdef TX_SAT_COUNT_EN
    check(tag, 32'(io_sat_count), 32'(sat_model));
`else
    check(tag, 32'(io_sat_count), 32'd0);
`endif
  endtask

  // wait (bounded) for the scoreboard to empty, then expect the underflow re-prime
  task automatic drain_and_reprime(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_empty_state"}, 32'(io_state), 32'd2);
    check({tag, "_empty_valid"}, 32'(io_dac_valid), 32'd0);
    tick();
    check({tag, "_reprime_state"}, 32'(io_state), 32'd1);
    check({tag, "_underflow"}, 32'(io_underflow), 32'd1);
    check({tag, "_reprime_valid"}, 32'(io_dac_valid), 32'd0);
    check({tag, "_reprime_mid"}, {io_dac_code_3, io_dac_code_2, io_dac_code_1, io_dac_code_0},
          32'h80808080);
  endtask

  // scoreboard: every DAC transfer must match the oldest expected code set
  always @(negedge clock) begin
    if (!reset && io_dac_valid && io_dac_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_output observed=%0h expected=none",
               {io_dac_code_3, io_dac_code_2, io_dac_code_1, io_dac_code_0});
      end
      if (exp_q.size() != 0)
        check("dac_codes", {io_dac_code_3, io_dac_code_2, io_dac_code_1, io_dac_code_0},
              exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; io_enable = 1'b0; io_clear_status = 1'b0; io_in_valid = 1'b0;
    io_dac_ready = 1'b0;
    io_in_bits_0 = '0; io_in_bits_1 = '0; io_in_bits_2 = '0; io_in_bits_3 = '0;
    tick();
    tick();
    check("rst_state", 32'(io_state), 32'd0);
    check("rst_valid", 32'(io_dac_valid), 32'd0);
    check("rst_codes", {io_dac_code_3, io_dac_code_2, io_dac_code_1, io_dac_code_0}, 32'h80808080);
    check("rst_ovf", 32'(io_overflow), 32'd0);
    check("rst_unf", 32'(io_underflow), 32'd0);
    check("rst_sat", 32'(io_sat_count), 32'd0);
    reset = 1'b0;

    // basic prime then stream, followed by underflow re-prime
    io_enable = 1'b1;
    io_dac_ready = 1'b1;
    tick();
    check("t1_prime", 32'(io_state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      push_cycle(8'd0, 8'd1, 8'hFF, 8'd50, 1'b1);
      check("t1_state", 32'(io_state), (i < 3) ? 32'd1 : 32'd2);
    end
    check("t1_code0", 32'(io_dac_code_0), 32'd128);
    check("t1_code1", 32'(io_dac_code_1), 32'd129);
    check("t1_code2", 32'(io_dac_code_2), 32'd127);
    check("t1_code3", 32'(io_dac_code_3), 32'd178);
    check_sat("t1_sat");
    drain_and_reprime("t1");
    clear_pulse();
    check("t1_unf_cleared", 32'(io_underflow), 32'd0);

    // clipping at both rails
    push_cycle(8'd127, 8'h80, 8'd100, 8'h9B, 1'b1);
    check_sat("t2_sat_first");
    push_cycle(8'hFF, 8'd2, 8'hFD, 8'd4, 1'b1);
    push_cycle(8'd10, 8'hEC, 8'd30, 8'hD8, 1'b1);
    push_cycle(8'd99, 8'h9D, 8'd101, 8'h9C, 1'b1);
    check("t2_state", 32'(io_state), 32'd2);
    check("t2_code0", 32'(io_dac_code_0), 32'd228);
    check("t2_code1", 32'(io_dac_code_1), 32'd28);
    check("t2_code2", 32'(io_dac_code_2), 32'd228);
    check("t2_code3", 32'(io_dac_code_3), 32'd28);
    check_sat("t2_sat_all");
    drain_and_reprime("t2");
    clear_pulse();

    // overflow with DAC stalled, then full push with simultaneous pop
    io_dac_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_rand(1'b1);
    check("t3_state", 32'(io_state), 32'd2);
    check("t3_ovf_before", 32'(io_overflow), 32'd0);
    check("t3_valid", 32'(io_dac_valid), 32'd1);
    push_rand(1'b0);
    check("t3_ovf_after", 32'(io_overflow), 32'd1);
    check_sat("t3_sat_drop");
    io_dac_ready = 1'b1;
    push_rand(1'b1);
    check("t3_ovf_sticky", 32'(io_overflow), 32'd1);
    check_sat("t3_sat_full_pop");
    drain_and_reprime("t3");

    // drain on disable; inputs during DRAIN are ignored
    io_dac_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_rand(1'b1);
    check("t5_stream", 32'(io_state), 32'd2);
    io_dac_ready = 1'b1;
    tick();
    io_dac_ready = 1'b0;
    io_enable = 1'b0;
    tick();
    check("t5_drain", 32'(io_state), 32'd3);
    check("t5_drain_valid", 32'(io_dac_valid), 32'd1);
    io_dac_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    check("t5_idle", 32'(io_state), 32'd0);
    check("t5_all_out", 32'(exp_q.size()), 32'd0);
    check("t5_valid", 32'(io_dac_valid), 32'd0);
    check("t5_mid", 32'(io_dac_code_2), 32'd128);
    check("t5_ovf_sticky", 32'(io_overflow), 32'd1);
    check("t5_unf_sticky", 32'(io_underflow), 32'd1);
    check_sat("t5_sat");
    push_rand(1'b0);
    check("t5_idle_hold", 32'(io_state), 32'd0);
    check("t5_idle_valid", 32'(io_dac_valid), 32'd0);

    // reset mid-stream discards queued data
    io_enable = 1'b1;
    io_dac_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) push_cycle(8'(i + 1), 8'd2, 8'd3, 8'd4, 1'b0);
    check("t6_stream", 32'(io_state), 32'd2);
    check("t6_valid_pre", 32'(io_dac_valid), 32'd1);
    reset = 1'b1;
    io_enable = 1'b0;
    tick();
    reset = 1'b0;
    sat_model = 0;
    check("t6_state", 32'(io_state), 32'd0);
    check("t6_valid", 32'(io_dac_valid), 32'd0);
    check("t6_ovf", 32'(io_overflow), 32'd0);
    check("t6_unf", 32'(io_underflow), 32'd0);
    check("t6_sat", 32'(io_sat_count), 32'd0);
    check("t6_mid", 32'(io_dac_code_0), 32'd128);
    io_dac_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_no_stale", 32'(io_dac_valid), 32'd0);
    io_enable = 1'b1;
    tick();
    check("t6_prime", 32'(io_state), 32'd1);
    push_cycle(8'd20, 8'd21, 8'd22, 8'd23, 1'b1);
    push_cycle(8'hF0, 8'hF1, 8'hF2, 8'hF3, 1'b1);
    push_cycle(8'd7, 8'd0, 8'h81, 8'd120, 1'b1);
    push_cycle(8'd64, 8'hC0, 8'd1, 8'hFE, 1'b1);
    check_sat("t6_sat_new");
    drain_and_reprime("t6");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
